// File: rtl/dcache_wbuf.sv
// Data-cache store write buffer: FIFO of dword entries with
// youngest-entry coalescing and byte-granular load forwarding.
module dcache_wbuf #(
  parameter int XLEN  = 64,
  parameter int NR_WB = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] waddr,
  input  logic [1:0]      wsize,
  input  logic [XLEN-1:0] wdata,
  input  logic            wvalid,
  output logic            wready,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_data,
  output logic [7:0]      mem_be,
  input  logic [XLEN-1:0] probe_addr,
  output logic [7:0]      probe_be,
  output logic [XLEN-1:0] probe_data,
  input  logic            flush_i,
  output logic            idle_o,
  output logic            misalign_o
);

  localparam int PW = $clog2(NR_WB);
  localparam int CW = PW + 1;
  localparam int AW = XLEN - 3;

  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [NR_WB-1:0] r_valid;
  logic [AW-1:0]   r_addr [NR_WB];
  logic [XLEN-1:0] r_data [NR_WB];
  logic [7:0]      r_be   [NR_WB];
  logic            r_misalign;

  logic [2:0]      w_off;
  logic [7:0]      w_mask;
  logic [15:0]     w_be16;
  logic [7:0]      w_be;
  logic [XLEN-1:0] w_sdata;
  logic [AW-1:0]   w_dw;
  logic            w_acc;
  logic            w_pop;
  logic            w_merge;
  logic            w_alloc;
  logic [PW-1:0]   w_tm1;
  logic [XLEN-1:0] w_mdata;
  logic [7:0]      w_mbe;
  logic [PW-1:0]   w_pi;
  logic            w_unused;

  assign w_unused = ^probe_addr[2:0];

  assign w_off   = waddr[2:0];
  assign w_dw    = waddr[XLEN-1:3];
  assign w_be16  = {8'h00, w_mask} << w_off;
  assign w_be    = w_be16[7:0];
  assign w_sdata = wdata << {w_off, 3'b000};
  assign w_tm1   = r_tail - PW'(1);

  assign wready  = rstn && !flush_i && (r_count < CW'(NR_WB));
  assign w_acc   = wvalid && wready;
  assign w_pop   = mem_valid && mem_ready;
  assign w_merge = w_acc && (r_count >= CW'(2)) &&
                   r_valid[w_tm1] && (r_addr[w_tm1] == w_dw);
  assign w_alloc = w_acc && !w_merge;

  assign mem_valid  = (r_count != '0);
  assign idle_o     = (r_count == '0);
  assign mem_addr   = {r_addr[r_head], 3'b000};
  assign mem_data   = r_data[r_head];
  assign mem_be     = r_be[r_head];
  assign misalign_o = r_misalign;

  // Size decode to an unshifted byte mask.
  always_comb begin
    w_mask = 8'h01;
    unique case (wsize)
      2'd0: w_mask = 8'h01;
      2'd1: w_mask = 8'h03;
      2'd2: w_mask = 8'h0F;
      2'd3: w_mask = 8'hFF;
    endcase
  end

  // Merged contents of the youngest entry when coalescing.
  always_comb begin
    w_mdata = r_data[w_tm1];
    for (int b = 0; b < 8; b++) begin
      if (w_be[b]) w_mdata[8*b +: 8] = w_sdata[8*b +: 8];
    end
    w_mbe = r_be[w_tm1] | w_be;
  end

  // Forwarding: walk oldest to youngest so younger bytes win.
  always_comb begin
    probe_be   = '0;
    probe_data = '0;
    w_pi       = '0;
    for (int i = 0; i < NR_WB; i++) begin
      w_pi = r_head + PW'(i);
      if (r_valid[w_pi] && (r_addr[w_pi] == probe_addr[XLEN-1:3])) begin
        for (int b = 0; b < 8; b++) begin
          if (r_be[w_pi][b]) begin
            probe_be[b]          = 1'b1;
            probe_data[8*b +: 8] = r_data[w_pi][8*b +: 8];
          end
        end
      end
    end
  end

  // Pointers, occupancy and the misalign pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_acc && (|w_be16[15:8]);
      if (w_alloc) r_tail <= r_tail + PW'(1);
      if (w_pop)   r_head <= r_head + PW'(1);
      r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
    end
  end

  // Entry valid bits; alloc and pop never hit the same slot.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= '0;
    end else begin
      if (w_pop)   r_valid[r_head] <= 1'b0;
      if (w_alloc) r_valid[r_tail] <= 1'b1;
    end
  end

  // Entry payload; gated by accept, which is low during reset.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= w_dw;
      r_data[r_tail] <= w_sdata;
      r_be[r_tail]   <= w_be;
    end else if (w_merge) begin
      r_data[w_tm1] <= w_mdata;
      r_be[w_tm1]   <= w_mbe;
    end
  end

endmodule
